keypad_event_queue: RTL and testbench

Debounces the raw key-pressed/key-code pair from the keypad poller/encoder pair and turns each accepted press into a single key event. Events are buffered in a small FIFO and handed to the calculator control FSM over a valid/ready handshake. This replaces the FSM's own "key_pressed && !key_pressed_prev" edge detection, so a key press cannot be lost while the FSM is busy in a calculate or display state.

---
 rtl/keypad_event_queue.sv | 187 ++++++++++++++++++
 tb/tb_keypad_event_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_queue.sv
// Keypad debouncer feeding a small event FIFO with a valid/ready output.
// Define KEYQ_REPEAT_EN to add auto-repeat events while a key stays held.
module keypad_event_queue #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEPTH           = 4,
    parameter int REPEAT_DELAY    = 512,
    parameter int REPEAT_PERIOD   = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_pressed_in,
    input  logic [3:0]               key_code_in,
    input  logic                     evt_ready,
    input  logic                     clear_in,
    output logic                     evt_valid,
    output logic [3:0]               evt_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
`ifdef KEYQ_REPEAT_EN
    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
`else
    localparam int CNT_MAX   = DEBOUNCE_CYCLES;
`endif
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DC_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    if (DEBOUNCE_CYCLES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_event_queue: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      cand_reg, cand_next;
    logic            push;
`ifdef KEYQ_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    logic            rep_reg, rep_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
`ifdef KEYQ_REPEAT_EN
            rep_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
`ifdef KEYQ_REPEAT_EN
            rep_reg   <= rep_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        push       = 1'b0;
`ifdef KEYQ_REPEAT_EN
        rep_next   = rep_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (key_pressed_in) begin
                    cand_next  = key_code_in;
                    cnt_next   = '0;
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!key_pressed_in || key_code_in != cand_reg) begin
                    state_next = IDLE;
                end else if (cnt_reg == DC_LAST) begin
                    push       = 1'b1;
                    cnt_next   = '0;
                    state_next = HELD;
`ifdef KEYQ_REPEAT_EN
                    rep_next   = 1'b0;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!key_pressed_in) begin
                    cnt_next   = '0;
                    state_next = RELEASE_WAIT;
                end
`ifdef KEYQ_REPEAT_EN
                // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                else if (cnt_reg == (rep_reg ? RP_LAST : RD_LAST)) begin
                    push     = 1'b1;
                    cnt_next = '0;
                    rep_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (key_pressed_in) begin
                    cnt_next   = '0;
                    state_next = HELD;
`ifdef KEYQ_REPEAT_EN
                    rep_next   = 1'b0;
`endif
                end else if (cnt_reg == DC_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [3:0]    mem [DEPTH];
    logic [AW:0]   wr_reg, rd_reg;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr_next;
    logic [3:0]    head_reg, head_next;
    logic          ovf_reg;
    logic          full, do_pop, do_push, drop;

    assign count        = wr_reg - rd_reg;
    assign full         = (count == FULL_COUNT);
    assign do_pop       = (count != '0) && evt_ready && !clear_in;
    assign do_push      = push && !clear_in && (!full || do_pop);
    assign drop         = push && !clear_in && full && !do_pop;
    assign rd_addr_next = rd_reg[AW-1:0] + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_reg[AW-1:0]] <= cand_reg;
    end

    // Head register keeps the output registered: it loads either the entry behind
    // the one being popped or the incoming code when it lands in an empty FIFO.
    always_comb begin
        head_next = head_reg;
        if (!clear_in) begin
            if (do_pop) begin
                if (count == (AW + 1)'(1)) begin
                    if (do_push) head_next = cand_reg;
                end else begin
                    head_next = mem[rd_addr_next];
                end
            end else if (count == '0 && do_push) begin
                head_next = cand_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_reg   <= '0;
            rd_reg   <= '0;
            head_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (clear_in) begin
            wr_reg   <= '0;
            rd_reg   <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            if (do_push) wr_reg <= wr_reg + 1'b1;
            if (do_pop)  rd_reg <= rd_reg + 1'b1;
            if (drop)    ovf_reg <= 1'b1;
            head_reg <= head_next;
        end
    end

    assign evt_valid  = (count != '0);
    assign evt_code   = head_reg;
    assign fifo_count = count;
    assign overflow   = ovf_reg;
endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench: segment-level model of press/release acceptance and a queue model of the FIFO.
module tb_keypad_event_queue;
    localparam int DC    = 4;
    localparam int DEPTH = 4;
    localparam int RD    = 32;
    localparam int RP    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_pressed_in = 1'b0;
    logic [3:0] key_code_in = 4'h0;
    logic       evt_ready = 1'b0;
    logic       clear_in = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [3:0] q[$];
    bit         ovf_m = 1'b0;
    bit         down = 1'b0;
    bit         cur_pressed = 1'b0;
    bit         seg_down0 = 1'b0;
    logic [3:0] cur_code = 4'h0;
    int         seg_idx = 0;
    int         hold_base = 0;

    keypad_event_queue #(
        .DEBOUNCE_CYCLES(DC),
        .DEPTH(DEPTH),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_pressed_in(key_pressed_in),
        .key_code_in(key_code_in),
        .evt_ready(evt_ready),
        .clear_in(clear_in),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("evt_valid", 8'(evt_valid), 8'(q.size() != 0));
        chk("fifo_count", 8'(fifo_count), 8'(q.size()));
        chk("overflow", 8'(overflow), 8'(ovf_m));
        if (q.size() != 0) chk("evt_code", 8'(evt_code), 8'(q[0]));
    endtask

    // One clock: decide from the segment position whether this edge produces an event.
    task automatic tick();
        bit ev;
        bit pop_ok;
        ev = 1'b0;
        if (key_pressed_in) begin
            if (!seg_down0 && !down && seg_idx == DC) begin
                ev = 1'b1;
                down = 1'b1;
                hold_base = DC;
            end
`ifdef KEYQ_REPEAT_EN
            else if (down && seg_idx >= hold_base + RD && ((seg_idx - hold_base - RD) % RP) == 0) begin
                ev = 1'b1;
            end
`endif
        end else if (down && seg_idx == DC) begin
            down = 1'b0;
        end
        @(posedge clk);
        if (clear_in) begin
            q.delete();
            ovf_m = 1'b0;
            $display("clear");
        end else begin
            pop_ok = (q.size() != 0) && evt_ready;
            if (pop_ok) begin
                $display("pop code=%h", q[0]);
                void'(q.pop_front());
            end
            if (ev) begin
                if (q.size() < DEPTH) begin
                    q.push_back(cur_code);
                    $display("event code=%h stored", cur_code);
                end else begin
                    ovf_m = 1'b1;
                    $display("event code=%h dropped", cur_code);
                end
            end
        end
        seg_idx++;
        #1;
        check_all();
    endtask

    // rmode: 0 never ready, 1 random ready/clear, 2 always ready, 3 ready only on the press-accept cycle
    task automatic run_seg(input bit pressed, input logic [3:0] code, input int len,
                           input int rmode, input int clr_at);
        if (!(pressed == cur_pressed && (!pressed || code == cur_code))) begin
            cur_pressed = pressed;
            cur_code = code;
            seg_idx = 0;
            seg_down0 = down;
            if (pressed && down) hold_base = 0;
        end
        for (int i = 0; i < len; i++) begin
            key_pressed_in = pressed;
            key_code_in = pressed ? code : 4'($urandom_range(0, 15));
            case (rmode)
                0: evt_ready = 1'b0;
                1: evt_ready = 1'($urandom_range(0, 1));
                2: evt_ready = 1'b1;
                default: evt_ready = pressed && seg_idx == DC;
            endcase
            clear_in = (i == clr_at) || (rmode == 1 && $urandom_range(0, 63) == 0);
            tick();
        end
        clear_in = 1'b0;
        evt_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 8'(evt_valid), 8'h0);
        chk("rst_code", 8'(evt_code), 8'h0);
        chk("rst_count", 8'(fifo_count), 8'h0);
        chk("rst_overflow", 8'(overflow), 8'h0);
        rst = 1'b0;

        // Reset while a second press is two cycles into debounce, with one event stored.
        run_seg(0, 4'h0, 3, 0, -1);
        run_seg(1, 4'h6, 8, 0, -1);
        run_seg(0, 4'h0, 6, 0, -1);
        run_seg(1, 4'h5, 3, 0, -1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 8'(evt_valid), 8'h0);
        chk("midrst_code", 8'(evt_code), 8'h0);
        chk("midrst_count", 8'(fifo_count), 8'h0);
        chk("midrst_overflow", 8'(overflow), 8'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", 8'(evt_valid), 8'h0);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        down = 1'b0;
        cur_pressed = 1'b0;
        run_seg(1, 4'h5, 10, 0, -1);
        run_seg(0, 4'h0, 10, 2, -1);

        // Clean press, then a single ready pulse.
        run_seg(1, 4'h7, 20, 0, -1);
        run_seg(0, 4'h0, 8, 0, -1);
        run_seg(0, 4'h0, 1, 2, -1);
        run_seg(0, 4'h0, 2, 0, -1);

        // Press bounce, then a held press with release bounce.
        for (int k = 0; k < 4; k++) begin
            run_seg(1, 4'h3, 2, 0, -1);
            run_seg(0, 4'h0, 2, 0, -1);
        end
        run_seg(1, 4'h3, 10, 0, -1);
        run_seg(0, 4'h0, 2, 0, -1);
        run_seg(1, 4'h3, 2, 0, -1);
        run_seg(0, 4'h0, 2, 0, -1);
        run_seg(1, 4'h3, 1, 0, -1);
        run_seg(0, 4'h0, 10, 0, -1);
        run_seg(0, 4'h0, 4, 2, -1);

        // Overflow with five presses, then drain in order.
        for (int k = 1; k <= 5; k++) begin
            run_seg(1, 4'(k), 6, 0, -1);
            run_seg(0, 4'h0, 6, 0, -1);
        end
        run_seg(0, 4'h0, 6, 2, -1);

        // Full FIFO with a pop on the same cycle as the fifth push.
        for (int k = 8; k <= 11; k++) begin
            run_seg(1, 4'(k), 6, 0, -1);
            run_seg(0, 4'h0, 6, 0, -1);
        end
        run_seg(1, 4'hC, 6, 3, -1);
        run_seg(0, 4'h0, 6, 0, -1);
        run_seg(0, 4'h0, 5, 2, -1);

        // Clear with two events stored and overflow set, ready asserted alongside.
        for (int k = 13; k <= 17; k++) begin
            run_seg(1, 4'(k), 6, 0, -1);
            run_seg(0, 4'h0, 6, 0, -1);
        end
        run_seg(0, 4'h0, 2, 2, -1);
        run_seg(0, 4'h0, 3, 2, 0);

        // Long hold: auto-repeat events appear only when the repeat macro is defined.
        run_seg(1, 4'h9, 60, 0, -1);
        run_seg(0, 4'h0, 8, 2, -1);

        for (int k = 0; k < 60; k++) begin
            run_seg(1, 4'($urandom_range(0, 15)), $urandom_range(1, 12), 1, -1);
            run_seg(0, 4'h0, $urandom_range(1, 12), 1, -1);
        end
        run_seg(0, 4'h0, 8, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
